// File: rtl/sodor_pkg.sv
// Shared constants, FSM state type and decode helper for the sodor5
// instruction-side sequencer.
package sodor_pkg;

  localparam logic [6:0]  OPC_OP_IMM       = 7'b0010011;
  localparam logic [31:0] NOP_WORD         = 32'h00000013;
  localparam int          INSTR_QUEUE_SIZE = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAD   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/iq_prog_buf.sv
// Program buffer: words are written in arrival order and read back by index.
// Also tracks the word count and whether the program has been sealed.
module iq_prog_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [31:0]      i_wr_data,
  input  logic             i_wr_last,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data,
  output logic [IDX_W:0]   o_cnt,
  output logic             o_sealed
);

  localparam logic [IDX_W:0] LAST_SLOT = (IDX_W+1)'(DEPTH - 1);

  logic [31:0]    r_mem [DEPTH];
  logic [IDX_W:0] r_cnt;
  logic           r_sealed;
  logic [IDX_W:0] w_base;

  // A clearing write restarts the program at slot 0 in the same cycle.
  assign w_base = i_clear ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[w_base[IDX_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sealed <= 1'b0;
    end else if (i_wr_en) begin
      r_cnt    <= w_base + (IDX_W+1)'(1);
      r_sealed <= i_wr_last || (w_base == LAST_SLOT);
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_cnt     = r_cnt;
  assign o_sealed  = r_sealed;

endmodule

// File: rtl/imem_iq_sequencer.sv
// Feeds a stored program to the sodor5 core one word per cycle, padding
// I-type ops with NOP bubbles and flushing the instruction queue at the end.
module imem_iq_sequencer
  import sodor_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int IDX_W        = 4,
  parameter int PAD_NOPS     = 4,
  parameter int DRAIN_CYCLES = INSTR_QUEUE_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        start,
  input  logic        stall,
  output logic [31:0] instr_data,
  output logic        control_fetch_i,
  output logic        control_shift_iq,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        done,
  output logic        err_illegal
);

  localparam int PAD_W   = (PAD_NOPS > 1) ? $clog2(PAD_NOPS) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PAD_W-1:0]   PAD_LOAD   = PAD_W'(PAD_NOPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic               PAD_EN     = (PAD_NOPS > 0);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [PAD_W-1:0]   r_pad_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_prog_end;
  logic               r_first;
  logic [31:0]        r_instr;
  logic               r_fetch;
  logic               r_shift;
  logic [31:0]        r_pc;
  logic               r_err;

  logic [31:0]        w_word;
  logic [IDX_W:0]     w_cnt;
  logic               w_sealed;
  logic               w_loadable;
  logic               w_accept;
  logic               w_clear;
  logic               w_start;
  logic               w_prog_empty;
  logic               w_last;
  logic               w_is_imm;
  logic               w_pad_req;
  logic               w_active;

  assign w_loadable   = (r_state == IDLE) || (r_state == DONE);
  assign load_ready   = w_loadable && !w_sealed && !w_cnt[IDX_W];
  assign w_accept     = load_valid && load_ready;
  assign w_clear      = w_accept && (r_state == DONE);
  assign w_start      = start && w_loadable;
  assign w_prog_empty = (w_cnt == '0) && !w_accept;
  assign w_last       = ({1'b0, r_idx} == (w_cnt - (IDX_W+1)'(1)));
  assign w_is_imm     = (get_opcode(w_word) == OPC_OP_IMM);
  assign w_pad_req    = PAD_EN && w_is_imm && (w_word != NOP_WORD);
  assign w_active     = ((r_state == RUN) || (r_state == PAD) || (r_state == DRAIN)) && !stall;

  iq_prog_buf #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_wr_en   (w_accept),
    .i_wr_data (load_data),
    .i_wr_last (load_last),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_word),
    .o_cnt     (w_cnt),
    .o_sealed  (w_sealed)
  );

  // pc_out tracks the slot on instr_data, so the first slot after start keeps 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_pad_cnt   <= '0;
      r_drain_cnt <= '0;
      r_prog_end  <= 1'b0;
      r_first     <= 1'b0;
      r_instr     <= '0;
      r_fetch     <= 1'b0;
      r_shift     <= 1'b0;
      r_pc        <= '0;
      r_err       <= 1'b0;
    end else begin
      r_fetch <= 1'b0;
      r_shift <= 1'b0;
      if (w_active) begin
        r_shift <= 1'b1;
        r_first <= 1'b0;
        if (!r_first) begin
          r_pc <= r_pc + 32'd4;
        end
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_clear) begin
            r_err   <= 1'b0;
            r_pc    <= '0;
            r_state <= IDLE;
          end
          if (w_start) begin
            r_idx       <= '0;
            r_pc        <= '0;
            r_first     <= 1'b1;
            r_drain_cnt <= '0;
            r_state     <= w_prog_empty ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            r_fetch    <= 1'b1;
            r_prog_end <= w_last;
            if (w_is_imm) begin
              r_instr <= w_word;
            end else begin
              r_instr <= NOP_WORD;
              r_err   <= 1'b1;
            end
            if (!w_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end
            if (w_pad_req) begin
              r_pad_cnt <= PAD_LOAD;
              r_state   <= PAD;
            end else if (w_last) begin
              r_drain_cnt <= '0;
              r_state     <= DRAIN;
            end
          end
        end
        PAD: begin
          if (!stall) begin
            r_fetch <= 1'b1;
            r_instr <= NOP_WORD;
            if (r_pad_cnt == '0) begin
              if (r_prog_end) begin
                r_drain_cnt <= '0;
                r_state     <= DRAIN;
              end else begin
                r_state <= RUN;
              end
            end else begin
              r_pad_cnt <= r_pad_cnt - PAD_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            r_instr <= '0;
            if (r_drain_cnt == DRAIN_LAST) begin
              r_state <= DONE;
            end else begin
              r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_data       = r_instr;
  assign control_fetch_i  = r_fetch;
  assign control_shift_iq = r_shift;
  assign pc_out           = r_pc;
  assign err_illegal      = r_err;
  assign busy             = (r_state == RUN) || (r_state == PAD) || (r_state == DRAIN);
  assign done             = (r_state == DONE);

endmodule
